// File: rtl/peripheral_ahb3_sram_slave.sv
// rtl/peripheral_ahb3_sram_slave.sv - AHB3-Lite slave backed by a word-addressed on-chip SRAM.
// Optional data-phase wait states are compiled in with PERIPHERAL_AHB3_WAIT_EN.
module peripheral_ahb3_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_ERR1, S_ERR2
`ifdef PERIPHERAL_AHB3_WAIT_EN
    , S_WAIT
`endif
  } state_t;

  state_t state, state_nxt;

  logic [IW+1:0]         addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  can_accept, accept, legal, load;
  logic                  size_ok, align_ok, range_ok;
  logic [3:0]            be;
  logic [IW-1:0]         idx;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

`ifdef PERIPHERAL_AHB3_WAIT_EN
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  logic [CW-1:0] cnt, cnt_nxt;
`endif

  // Address phases arriving while in WAIT or ERR1 are protocol violations and are dropped.
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = HSEL & HREADY & HTRANS[1] & can_accept;

  assign size_ok  = (HSIZE <= 3'd2);
  assign align_ok = (HSIZE == 3'd1) ? !HADDR[0] :
                    (HSIZE == 3'd2) ? (HADDR[1:0] == 2'b00) : 1'b1;
  assign range_ok = (HADDR[HADDR_SIZE-1:IW+2] == '0);
  assign legal    = size_ok & align_ok & range_ok;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
`ifdef PERIPHERAL_AHB3_WAIT_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept) begin
          state_nxt = S_IDLE;
        end else if (!legal) begin
          state_nxt = S_ERR1;
        end else begin
          load = 1'b1;
`ifdef PERIPHERAL_AHB3_WAIT_EN
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CW'(WAIT_STATES - 1);
          end else begin
            state_nxt = S_DATA;
          end
`else
          state_nxt = S_DATA;
`endif
        end
      end
      S_ERR1: state_nxt = S_ERR2;
`ifdef PERIPHERAL_AHB3_WAIT_EN
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_DATA;
        else           cnt_nxt   = cnt - 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
`ifdef PERIPHERAL_AHB3_WAIT_EN
      cnt     <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef PERIPHERAL_AHB3_WAIT_EN
      cnt   <= cnt_nxt;
`endif
      if (load) begin
        addr_q  <= HADDR[IW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
    end
  end

  assign HREADYOUT = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign idx = addr_q[IW+1:2];

  // Storage is deliberately not reset; the FSM reset alone drops a pending write.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == S_DATA && !write_q) ? mem[idx] : '0;

  logic unused_ok;
  assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

endmodule

// File: doc/peripheral_ahb3_sram_slave.md
# peripheral_ahb3_sram_slave

AHB3-Lite slave that terminates transfers issued through the `peripheral_interface` slave modport and backs them with an on-chip word-addressed SRAM array. It sits directly downstream of the AHB3-Lite master/interconnect in the MPSoC peripheral subsystem. It decodes address and data phases and supports byte, halfword and word writes. It inserts optional wait states and generates the two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- HADDR_SIZE, 32, address bus width
- HDATA_SIZE, 32, data bus width; only 32 is supported
- MEM_DEPTH, 256, number of 32-bit words; power of two
- WAIT_STATES, 1, data-phase wait cycles per transfer; used only when PERIPHERAL_AHB3_WAIT_EN is defined

Ports:
- HCLK  input  1  single clock; all logic on its rising edge
- HRESETn  input  1  asynchronous, active-low reset
- HSEL  input  1  slave select
- HADDR  input  HADDR_SIZE  byte address (address phase)
- HWDATA  input  HDATA_SIZE  write data (data phase)
- HRDATA  output  HDATA_SIZE  read data (data phase)
- HWRITE  input  1  1 = write
- HSIZE  input  3  transfer size, 0 = byte, 1 = half, 2 = word
- HBURST  input  3  burst type; accepted, not used for decode
- HPROT  input  4  protection; ignored
- HTRANS  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- HMASTLOCK  input  1  ignored
- HREADY  input  1  bus-wide ready; address phase sampled only when 1
- HREADYOUT  output  1  slave ready
- HRESP  output  1  0 OKAY, 1 ERROR

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1]. Latch HADDR, HWRITE and HSIZE into the data-phase registers.
- A transfer is illegal if any of the following holds:
  - HSIZE > 2
  - address is misaligned (half with HADDR[0]=1; word with HADDR[1:0]≠0)
  - HADDR ≥ 4*MEM_DEPTH
- IDLE/BUSY selected, or HSEL=0: no access; next data phase is zero-wait OKAY.
- FSM states:
  - IDLE: accept legal → WAIT if WAIT_STATES>0 (macro on), else DATA. Accept illegal → ERR1.
  - WAIT: count down from WAIT_STATES; at zero → DATA.
  - DATA: one cycle with HREADYOUT=1. A new accept in the same cycle re-enters WAIT/DATA/ERR1; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept handled as in DATA.
- Word index is addr_q[log2(MEM_DEPTH)+1:2]. Byte lanes are little-endian:
  - byte: lane addr_q[1:0]
  - half: lanes {addr_q[1],0} and {addr_q[1],1}
  - word: all lanes
- Write: the masked HWDATA lanes are committed at the rising edge that ends the DATA state. Unselected lanes are unchanged.
- Read: HRDATA = mem[index] combinationally during DATA for a read. Otherwise HRDATA = 0. All 32 bits are returned regardless of HSIZE.
- Back-to-back write→read of the same word returns the new data, because the write commits before the read's data phase.
- Illegal transfers never modify memory.
- SRAM contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
- Zero-wait latency: address phase in cycle N; data phase in cycle N+1 with HREADYOUT=1.
- With wait states: HREADYOUT=0 for cycles N+1..N+WAIT_STATES; HREADYOUT=1 in cycle N+WAIT_STATES+1.
- Error response: N+1 gives HREADYOUT=0/HRESP=1; N+2 gives HREADYOUT=1/HRESP=1.
- While HREADYOUT=0, HREADY is 0 bus-wide, so no new address phase is sampled.
- An accept during ERR1 or WAIT is impossible by protocol. If one occurs anyway, it is ignored.
- Reset asserted mid-transfer: FSM returns to IDLE and outputs go to reset values immediately. A pending write is dropped.
- HRESP changes only with the FSM; it is never 1 while in IDLE or DATA.

## Configuration
- PERIPHERAL_AHB3_WAIT_EN defined: the WAIT state and counter are compiled in, and every legal transfer takes WAIT_STATES extra cycles. WAIT_STATES=0 behaves as zero-wait.
- Not defined: the WAIT state and counter are absent, WAIT_STATES is ignored, and every legal transfer is zero-wait.

## Test plan
- Reset: hold HRESETn=0 → HREADYOUT=1, HRESP=0, HRDATA=0; release, drive IDLE for 3 cycles → outputs unchanged.
- Word write 0xDEADBEEF @0x10, then word read @0x10 back-to-back (macro off) → read data phase one cycle later, HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA @0x11, then half write 0x5566 @0x12 over 0x00000000 @0x10 → word read @0x10 returns 0x5566AA00.
- Word read @0x402 (misaligned), then word write @0x400 with MEM_DEPTH=256 (out of range) → each gives ERR1 then ERR2, i.e. HREADYOUT 0→1 with HRESP=1; memory unchanged.
- Macro on, WAIT_STATES=2: write then read @0x20 → HREADYOUT low for exactly 2 cycles per transfer; data correct.
- Assert HRESETn=0 during the WAIT state of a write @0x30 holding prior value 0x11111111 → immediate reset outputs; a later read @0x30 returns 0x11111111.
